div_unit: RTL and testbench

- Multi-cycle radix-2 restoring divider serving the EX stage's DIV/DIVU requests.
- Responder end of the EX divide handshake. EX drives the operands, start and signedness. This block returns a 64-bit {remainder, quotient} and a ready pulse.
- Instantiated at top level next to the EX stage. Its result goes to hi/lo through the EX whilo path.

---
 rtl/div_unit_pkg.sv | 38 +++
 rtl/div_unit_step.sv | 23 ++
 rtl/div_unit.sv | 176 +++++++++++++++++
 tb/tb_div_unit.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/div_unit_pkg.sv
// Shared divider definitions: handshake macros, FSM encoding, widths and result layout.
// Optional annul support is selected with the DIV_ANNUL_EN macro in div_unit.
`ifndef DIV_UNIT_DEFINES_SVH
`define DIV_UNIT_DEFINES_SVH
`define RSTENABLE          1'b1
`define DIVSTART           1'b1
`define DIVSTOP            1'b0
`define DIVRESULTREADY     1'b1
`define DIVRESULTNOTREADY  1'b0
`define DIV_FREE_ENC       2'b00
`define DIV_BYZERO_ENC     2'b01
`define DIV_ON_ENC         2'b10
`define DIV_END_ENC        2'b11
`define DIV_CNT_LAST       31
`endif

package div_unit_pkg;

  localparam int unsigned DIV_DATA_W = 32;
  localparam int unsigned DIV_CNT_W  = 5;

  // Counter value of the final restoring step
  localparam logic [DIV_CNT_W-1:0] DIV_CNT_LAST = DIV_CNT_W'(`DIV_CNT_LAST);

  typedef enum logic [1:0] {
    DIV_FREE   = `DIV_FREE_ENC,
    DIV_BYZERO = `DIV_BYZERO_ENC,
    DIV_ON     = `DIV_ON_ENC,
    DIV_END    = `DIV_END_ENC
  } div_state_e;

  // Result word as consumed by the hi/lo write path
  typedef struct packed {
    logic [DIV_DATA_W-1:0] rem;
    logic [DIV_DATA_W-1:0] quo;
  } div_result_t;

endpackage

// File: rtl/div_unit_step.sv
// div_step: one combinational radix-2 restoring division step.
module div_step #(
  parameter int unsigned W = 32
) (
  input  logic [W-1:0] rem,
  input  logic         next_bit,
  input  logic [W-1:0] divisor,
  output logic [W-1:0] rem_next_c,
  output logic         quo_bit_c
);

  logic [W:0] minuend;
  logic [W:0] diff;

  // Trial subtract; keep the difference only when it did not borrow
  always_comb begin
    minuend    = {rem, next_bit};
    diff       = minuend - {1'b0, divisor};
    quo_bit_c  = ~diff[W];
    rem_next_c = diff[W] ? minuend[W-1:0] : diff[W-1:0];
  end

endmodule

// File: rtl/div_unit.sv
// div_unit: multi-cycle radix-2 restoring divider for EX-stage DIV/DIVU.
// Returns {remainder, quotient} with a registered ready flag.
// Define DIV_ANNUL_EN to add the annul_i input that cancels an in-flight divide.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int unsigned DATA_W = DIV_DATA_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  signed_div_i,
  input  logic [DATA_W-1:0]     opdata1_i,
  input  logic [DATA_W-1:0]     opdata2_i,
  input  logic                  start_i,
`ifdef DIV_ANNUL_EN
  input  logic                  annul_i,
`endif
  output logic [2*DATA_W-1:0]   result_o,
  output logic                  ready_o
);

  div_state_e state_q;
  div_state_e state_d;

  logic                 annul_c;
  logic [DATA_W-1:0]    dvd_q, dvd_d;
  logic [DATA_W-1:0]    dvs_q, dvs_d;
  logic [DATA_W-1:0]    rem_q, rem_d;
  logic [DATA_W-1:0]    quo_q, quo_d;
  logic [DIV_CNT_W-1:0] cnt_q, cnt_d;
  logic                 neg_quo_q, neg_quo_d;
  logic                 neg_rem_q, neg_rem_d;
  logic                 ready_d;
  logic [2*DATA_W-1:0]  result_d;
  logic [DATA_W-1:0]    step_rem_c;
  logic                 step_bit_c;
  logic [DATA_W-1:0]    quo_fin_c;
  logic                 start_ok_c;
  div_result_t          res_c;

  function automatic logic [DATA_W-1:0] twos_neg(input logic [DATA_W-1:0] v);
    return (~v) + DATA_W'(1);
  endfunction

`ifdef DIV_ANNUL_EN
  assign annul_c = annul_i;
`else
  assign annul_c = 1'b0;
`endif

  // A start in FREE is accepted unless an annul is sampled in the same cycle
  assign start_ok_c = (start_i == `DIVSTART) && !annul_c;

  div_step #(.W(DATA_W)) u_step (
    .rem        (rem_q),
    .next_bit   (dvd_q[DATA_W-1]),
    .divisor    (dvs_q),
    .rem_next_c (step_rem_c),
    .quo_bit_c  (step_bit_c)
  );

  assign quo_fin_c = {quo_q[DATA_W-2:0], step_bit_c};

  // State register
  always_ff @(posedge clk) begin
    if (rst == `RSTENABLE) state_q <= DIV_FREE;
    else                   state_q <= state_d;
  end

  // Next-state logic; DIV_END always presents ready for at least one cycle
  always_comb begin
    state_d = state_q;
    case (state_q)
      DIV_FREE: begin
        if (start_ok_c) state_d = (opdata2_i == '0) ? DIV_BYZERO : DIV_ON;
      end
      DIV_BYZERO: begin
        state_d = annul_c ? DIV_FREE : DIV_END;
      end
      DIV_ON: begin
        if (annul_c)                   state_d = DIV_FREE;
        else if (cnt_q == DIV_CNT_LAST) state_d = DIV_END;
      end
      DIV_END: begin
        if (ready_o == `DIVRESULTREADY && start_i == `DIVSTOP) state_d = DIV_FREE;
      end
      default: state_d = DIV_FREE;
    endcase
  end

  // Datapath and output next values
  always_comb begin
    dvd_d     = dvd_q;
    dvs_d     = dvs_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    cnt_d     = cnt_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    ready_d   = `DIVRESULTNOTREADY;
    result_d  = '0;
    res_c     = '{rem: rem_q, quo: quo_q};
    case (state_q)
      DIV_FREE: begin
        if (start_ok_c) begin
          rem_d = '0;
          quo_d = '0;
          cnt_d = '0;
          if (signed_div_i) begin
            dvd_d     = opdata1_i[DATA_W-1] ? twos_neg(opdata1_i) : opdata1_i;
            dvs_d     = opdata2_i[DATA_W-1] ? twos_neg(opdata2_i) : opdata2_i;
            neg_quo_d = opdata1_i[DATA_W-1] ^ opdata2_i[DATA_W-1];
            neg_rem_d = opdata1_i[DATA_W-1];
          end else begin
            dvd_d     = opdata1_i;
            dvs_d     = opdata2_i;
            neg_quo_d = 1'b0;
            neg_rem_d = 1'b0;
          end
        end
      end
      DIV_BYZERO: begin
        if (!annul_c) begin
          rem_d = '0;
          quo_d = '0;
        end
      end
      DIV_ON: begin
        if (!annul_c) begin
          dvd_d = DATA_W'(dvd_q << 1);
          cnt_d = cnt_q + DIV_CNT_W'(1);
          if (cnt_q == DIV_CNT_LAST) begin
            quo_d = neg_quo_q ? twos_neg(quo_fin_c) : quo_fin_c;
            rem_d = neg_rem_q ? twos_neg(step_rem_c) : step_rem_c;
          end else begin
            quo_d = quo_fin_c;
            rem_d = step_rem_c;
          end
        end
      end
      DIV_END: begin
        if (!(ready_o == `DIVRESULTREADY && start_i == `DIVSTOP)) begin
          ready_d  = `DIVRESULTREADY;
          result_d = res_c;
        end
      end
      default: ;
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk) begin
    if (rst == `RSTENABLE) begin
      dvd_q     <= '0;
      dvs_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      cnt_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      ready_o   <= `DIVRESULTNOTREADY;
      result_o  <= '0;
    end else begin
      dvd_q     <= dvd_d;
      dvs_q     <= dvs_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      cnt_q     <= cnt_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      ready_o   <= ready_d;
      result_o  <= result_d;
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: stimulus pushes expected results, a monitor checks them.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        signed_div;
  logic [31:0] opdata1;
  logic [31:0] opdata2;
  logic        start;
  logic        annul;
  logic [63:0] result;
  logic        ready;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  logic ready_prev = 1'b0;

  typedef struct {
    logic [63:0] res;
    int          cyc;
  } exp_t;

  exp_t sb[$];

  div_unit dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div),
    .opdata1_i    (opdata1),
    .opdata2_i    (opdata2),
    .start_i      (start),
`ifdef DIV_ANNUL_EN
    .annul_i      (annul),
`endif
    .result_o     (result),
    .ready_o      (ready)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every rising ready must match the oldest expectation
  always @(negedge clk) begin : monitor
    exp_t e;
    if (ready === 1'b1 && ready_prev !== 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ready cyc=%0d result=%h", cyc, result);
      end else begin
        e = sb.pop_front();
        checks++;
        if (result !== e.res) begin
          errors++;
          $display("FAIL result cyc=%0d got=%h exp=%h", cyc, result, e.res);
        end
        checks++;
        if (cyc != e.cyc) begin
          errors++;
          $display("FAIL latency got_cyc=%0d exp_cyc=%0d", cyc, e.cyc);
        end
      end
    end
    ready_prev <= ready;
  end

  task automatic check_outs(input string name, input logic exp_rdy, input logic [63:0] exp_res);
    checks++;
    if (ready !== exp_rdy || result !== exp_res) begin
      errors++;
      $display("FAIL %s ready=%b result=%h exp_ready=%b exp_result=%h",
               name, ready, result, exp_rdy, exp_res);
    end
  endtask

  // Issue one divide, hold start through ready, then release
  task automatic run_div(input string name, input logic sgn, input logic [31:0] a,
                         input logic [31:0] b, input logic [63:0] exp_res, input int lat);
    exp_t e;
    int n;
    @(posedge clk); #1;
    signed_div = sgn;
    opdata1    = a;
    opdata2    = b;
    start      = 1'b1;
    e.res = exp_res;
    e.cyc = cyc + 1 + lat;
    sb.push_back(e);
    @(posedge clk); #1;
    opdata1    = ~a;
    opdata2    = 32'h0;
    signed_div = ~sgn;
    n = 0;
    while (ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (ready !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout ready=%b", name, ready);
      start = 1'b0;
    end else begin
      @(negedge clk);
      check_outs({name, "_hold"}, 1'b1, exp_res);
      start = 1'b0;
      @(negedge clk);
      check_outs({name, "_release"}, 1'b0, 64'h0);
    end
  endtask

  initial begin
    rst        = 1'b1;
    signed_div = 1'b0;
    opdata1    = '0;
    opdata2    = '0;
    start      = 1'b0;
    annul      = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_outs("reset_state", 1'b0, 64'h0);
    rst = 1'b0;

    run_div("u_100_7",     1'b0, 32'd100,       32'd7,         64'h00000002_0000000E, 33);
    run_div("s_m7_2",      1'b1, 32'hFFFFFFF9,  32'h00000002,  64'hFFFFFFFF_FFFFFFFD, 33);
    run_div("s_7_m2",      1'b1, 32'h00000007,  32'hFFFFFFFE,  64'h00000001_FFFFFFFD, 33);
    run_div("s_m8_m3",     1'b1, 32'hFFFFFFF8,  32'hFFFFFFFD,  64'hFFFFFFFE_00000002, 33);
    run_div("u_5_0",       1'b0, 32'd5,         32'd0,         64'h0,                 2);
    run_div("u_max_1",     1'b0, 32'hFFFFFFFF,  32'd1,         64'h00000000_FFFFFFFF, 33);
    run_div("s_min_m1",    1'b1, 32'h80000000,  32'hFFFFFFFF,  64'h00000000_80000000, 33);
    run_div("u_min_max",   1'b0, 32'h80000000,  32'hFFFFFFFF,  64'h80000000_00000000, 33);

    // Reset sampled at E10 of an in-flight divide
    @(posedge clk); #1;
    signed_div = 1'b0;
    opdata1    = 32'd100;
    opdata2    = 32'd7;
    start      = 1'b1;
    @(posedge clk);
    repeat (9) @(posedge clk);
    #1;
    rst   = 1'b1;
    start = 1'b0;
    @(posedge clk); #1;
    check_outs("reset_mid_div", 1'b0, 64'h0);
    rst = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    check_outs("reset_idle", 1'b0, 64'h0);
    run_div("u_9_3", 1'b0, 32'd9, 32'd3, 64'h00000000_00000003, 33);

`ifdef DIV_ANNUL_EN
    // Annul sampled at E5 cancels the divide
    @(posedge clk); #1;
    signed_div = 1'b0;
    opdata1    = 32'd100;
    opdata2    = 32'd7;
    start      = 1'b1;
    @(posedge clk);
    repeat (4) @(posedge clk);
    #1;
    annul = 1'b1;
    @(posedge clk); #1;
    annul = 1'b0;
    start = 1'b0;
    check_outs("annul_on", 1'b0, 64'h0);
    // Annul in FREE blocks a start in the same cycle
    start = 1'b1;
    annul = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    annul = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    check_outs("annul_idle", 1'b0, 64'h0);
    run_div("annul_next", 1'b0, 32'd9, 32'd3, 64'h00000000_00000003, 33);
`endif

    repeat (3) @(posedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_pending got=%0d exp=0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
